axi_line_master: RTL and testbench

AXI4 initiator that turns single cache-line read/write requests into fixed-length INCR bursts on the SoC AXI fabric. It sits between a line-based client (cache refill/writeback, DMA) and the AXI interconnect, the initiator counterpart of the AXI-to-SRAM slave adapter. One outstanding transaction at a time; full-width, line-aligned beats only.

---
 rtl/axi_line_master.sv | 182 ++++++++++++++++++
 tb/tb_axi_line_master.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_line_master.sv
// AXI4 initiator: turns single cache-line read/write requests into fixed-length INCR bursts.
// One outstanding transaction; all AXI outputs are register- or state-decoded.
module axi_line_master #(
  parameter int unsigned AXI_ID_WIDTH   = 7,
  parameter int unsigned AXI_ADDR_WIDTH = 48,
  parameter int unsigned AXI_DATA_WIDTH = 128,
  parameter int unsigned LINE_BEATS     = 4,
  parameter int unsigned TXN_ID         = 0
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 req_valid_i,
  output logic                                 req_ready_o,
  input  logic                                 req_we_i,
  input  logic [AXI_ADDR_WIDTH-1:0]            req_addr_i,
  input  logic [LINE_BEATS*AXI_DATA_WIDTH-1:0] req_wdata_i,
  output logic                                 rsp_valid_o,
  output logic [LINE_BEATS*AXI_DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                                 rsp_err_o,
  output logic                                 aw_valid,
  input  logic                                 aw_ready,
  output logic [AXI_ADDR_WIDTH-1:0]            aw_addr,
  output logic [AXI_ID_WIDTH-1:0]              aw_id,
  output logic [7:0]                           aw_len,
  output logic [2:0]                           aw_size,
  output logic [1:0]                           aw_burst,
  output logic [3:0]                           aw_cache,
  output logic [2:0]                           aw_prot,
  output logic                                 w_valid,
  input  logic                                 w_ready,
  output logic [AXI_DATA_WIDTH-1:0]            w_data,
  output logic [AXI_DATA_WIDTH/8-1:0]          w_strb,
  output logic                                 w_last,
  input  logic                                 b_valid,
  output logic                                 b_ready,
  input  logic [AXI_ID_WIDTH-1:0]              b_id,
  input  logic [1:0]                           b_resp,
  output logic                                 ar_valid,
  input  logic                                 ar_ready,
  output logic [AXI_ADDR_WIDTH-1:0]            ar_addr,
  output logic [AXI_ID_WIDTH-1:0]              ar_id,
  output logic [7:0]                           ar_len,
  output logic [2:0]                           ar_size,
  output logic [1:0]                           ar_burst,
  output logic [3:0]                           ar_cache,
  output logic [2:0]                           ar_prot,
  input  logic                                 r_valid,
  output logic                                 r_ready,
  input  logic [AXI_DATA_WIDTH-1:0]            r_data,
  input  logic [AXI_ID_WIDTH-1:0]              r_id,
  input  logic [1:0]                           r_resp,
  input  logic                                 r_last
);

  localparam int unsigned LINE_W = LINE_BEATS * AXI_DATA_WIDTH;
  localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;
  localparam int unsigned OFF_W  = $clog2(LINE_BEATS * STRB_W);
  localparam int unsigned CNT_W  = $clog2(LINE_BEATS);
  localparam logic [CNT_W-1:0]          LAST_BEAT = CNT_W'(LINE_BEATS - 1);
  localparam logic [AXI_ID_WIDTH-1:0]   ID        = AXI_ID_WIDTH'(TXN_ID);
  localparam logic [AXI_ADDR_WIDTH-1:0] ALIGN_MASK =
    ~((AXI_ADDR_WIDTH'(1) << OFF_W) - AXI_ADDR_WIDTH'(1));

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_ADDR = 3'd1;
  localparam logic [2:0] S_RD_DATA = 3'd2;
  localparam logic [2:0] S_WR      = 3'd3;
  localparam logic [2:0] S_WR_RESP = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]                r_state;
  logic [AXI_ADDR_WIDTH-1:0] r_addr;
  logic [LINE_W-1:0]         r_line;
  logic [LINE_W-1:0]         r_rdata;
  logic [CNT_W-1:0]          r_cnt;
  logic                      r_aw_done;
  logic                      r_w_done;
  logic                      r_err;

  logic              w_aw_fire;
  logic              w_w_fire;
  logic              w_wlast_fire;
  logic              w_r_bad;
  logic [LINE_W-1:0] w_line_nxt;

  assign w_aw_fire    = aw_valid & aw_ready;
  assign w_w_fire     = w_valid & w_ready;
  assign w_wlast_fire = w_w_fire & (r_cnt == LAST_BEAT);
  assign w_r_bad      = (r_resp != 2'b00) | (r_id != ID) | (r_last != (r_cnt == LAST_BEAT));

  // r_line doubles as the write source and the read assembly buffer.
  always_comb begin
    w_line_nxt = r_line;
    w_line_nxt[r_cnt*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = r_data;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_line    <= '0;
      r_rdata   <= '0;
      r_cnt     <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid_i) begin
            r_addr    <= req_addr_i & ALIGN_MASK;
            r_line    <= req_wdata_i;
            r_cnt     <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_err     <= 1'b0;
            r_state   <= req_we_i ? S_WR : S_RD_ADDR;
          end
        end
        S_RD_ADDR: begin
          if (ar_ready) r_state <= S_RD_DATA;
        end
        S_RD_DATA: begin
          if (r_valid) begin
            r_line <= w_line_nxt;
            r_cnt  <= r_cnt + CNT_W'(1);
            r_err  <= r_err | w_r_bad;
            if (r_cnt == LAST_BEAT) begin
              r_rdata <= w_line_nxt;
              r_state <= S_DONE;
            end
          end
        end
        S_WR: begin
          if (w_aw_fire) r_aw_done <= 1'b1;
          if (w_w_fire) r_cnt <= r_cnt + CNT_W'(1);
          if (w_wlast_fire) r_w_done <= 1'b1;
          if ((r_aw_done | w_aw_fire) && (r_w_done | w_wlast_fire)) r_state <= S_WR_RESP;
        end
        S_WR_RESP: begin
          if (b_valid) begin
            r_err   <= r_err | (b_resp != 2'b00) | (b_id != ID);
            r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o = (r_state == S_IDLE);
  assign rsp_valid_o = (r_state == S_DONE);
  assign rsp_err_o   = r_err;
  assign rsp_rdata_o = r_rdata;

  assign ar_valid = (r_state == S_RD_ADDR);
  assign ar_addr  = r_addr;
  assign ar_id    = ID;
  assign ar_len   = 8'(LINE_BEATS - 1);
  assign ar_size  = 3'($clog2(STRB_W));
  assign ar_burst = 2'b01;
  assign ar_cache = 4'b0010;
  assign ar_prot  = 3'b000;
  assign r_ready  = (r_state == S_RD_DATA);

  assign aw_valid = (r_state == S_WR) & ~r_aw_done;
  assign aw_addr  = r_addr;
  assign aw_id    = ID;
  assign aw_len   = 8'(LINE_BEATS - 1);
  assign aw_size  = 3'($clog2(STRB_W));
  assign aw_burst = 2'b01;
  assign aw_cache = 4'b0010;
  assign aw_prot  = 3'b000;

  assign w_valid = (r_state == S_WR) & ~r_w_done;
  assign w_data  = r_line[r_cnt*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
  assign w_strb  = '1;
  assign w_last  = w_valid & (r_cnt == LAST_BEAT);
  assign b_ready = (r_state == S_WR_RESP);

endmodule

// File: tb/tb_axi_line_master.sv
// Directed + randomized bench for axi_line_master acting as the AXI slave with a memory model.
// Expected responses and write beats are queued at request time and compared on DUT output.
module tb_axi_line_master;

  localparam int IW = 7;
  localparam int AW = 48;
  localparam int DW = 128;
  localparam int LB = 4;
  localparam int LW = LB * DW;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [LW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic [LW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          aw_valid, aw_ready = 1'b0;
  logic [AW-1:0] aw_addr;
  logic [IW-1:0] aw_id;
  logic [7:0]    aw_len;
  logic [2:0]    aw_size;
  logic [1:0]    aw_burst;
  logic [3:0]    aw_cache;
  logic [2:0]    aw_prot;
  logic          w_valid, w_ready = 1'b0;
  logic [DW-1:0] w_data;
  logic [SW-1:0] w_strb;
  logic          w_last;
  logic          b_valid = 1'b0, b_ready;
  logic [IW-1:0] b_id = '0;
  logic [1:0]    b_resp = '0;
  logic          ar_valid, ar_ready = 1'b0;
  logic [AW-1:0] ar_addr;
  logic [IW-1:0] ar_id;
  logic [7:0]    ar_len;
  logic [2:0]    ar_size;
  logic [1:0]    ar_burst;
  logic [3:0]    ar_cache;
  logic [2:0]    ar_prot;
  logic          r_valid = 1'b0, r_ready;
  logic [DW-1:0] r_data = '0;
  logic [IW-1:0] r_id = '0;
  logic [1:0]    r_resp = '0;
  logic          r_last = 1'b0;

  axi_line_master #(
    .AXI_ID_WIDTH(IW), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .LINE_BEATS(LB), .TXN_ID(0)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_id(aw_id),
    .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst), .aw_cache(aw_cache),
    .aw_prot(aw_prot),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
    .b_valid(b_valid), .b_ready(b_ready), .b_id(b_id), .b_resp(b_resp),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_id(ar_id),
    .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst), .ar_cache(ar_cache),
    .ar_prot(ar_prot),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_id(r_id), .r_resp(r_resp),
    .r_last(r_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [LW-1:0] rdata;
    logic          err;
    logic          is_rd;
  } rsp_t;

  int            checks = 0;
  int            failures = 0;
  rsp_t          rsp_q[$];
  logic [DW-1:0] wbeat_q[$];
  logic [DW-1:0] mem[longint];

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rd_mem(input longint a);
    logic [31:0] lo;
    if (mem.exists(a)) return mem[a];
    lo = a[31:0];
    return {lo ^ 32'hC0DE_0000, lo, ~lo, lo + 32'h5A5A_0000};
  endfunction

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int i = 0; i < LW / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  function automatic bit go(input int busy);
    return $urandom_range(99) >= busy;
  endfunction

  task automatic idle_inputs();
    ar_ready = 0; aw_ready = 0; w_ready = 0; r_valid = 0; b_valid = 0; r_last = 0;
  endtask

  // One request plus the slave side of the fabric. busy: % of cycles a ready/valid is withheld.
  task automatic run_txn(input bit we, input logic [AW-1:0] addr, input logic [LW-1:0] wdata,
                         input int busy, input int aw_delay, input int err_beat,
                         input int last_beat, input bit b_bad, input int exp_lat,
                         input int rst_beat);
    logic [AW-1:0] base;
    rsp_t          e;
    rsp_t          got;
    int            n, rb, wb, nb;
    bit            done;
    bit            p_ar, p_aw, p_w;
    logic [AW-1:0] p_ar_addr, p_aw_addr;
    logic [DW-1:0] p_w_data, exp_beat;
    logic          p_w_last;

    base = addr & ~48'h3F;
    e.is_rd = !we;
    e.rdata = '0;
    if (we) begin
      for (int i = 0; i < LB; i++) begin
        wbeat_q.push_back(wdata[i*DW +: DW]);
        mem[longint'(base) + i * SW] = wdata[i*DW +: DW];
      end
      e.err = b_bad;
    end else begin
      for (int i = 0; i < LB; i++) e.rdata[i*DW +: DW] = rd_mem(longint'(base) + i * SW);
      e.err = (err_beat >= 0) || (last_beat != LB - 1);
    end
    rsp_q.push_back(e);

    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1; req_we = we; req_addr = addr; req_wdata = wdata;
    n = 0; rb = 0; wb = 0; nb = 0; done = 0;
    p_ar = 0; p_aw = 0; p_w = 0;
    p_ar_addr = '0; p_aw_addr = '0; p_w_data = '0; p_w_last = 0;

    while (n < 300 && !done) begin
      @(negedge clk);
      n++;
      req_valid = 0;
      if (p_ar) chk("ar_hold", {ar_valid, ar_addr}, {1'b1, p_ar_addr});
      if (p_aw) chk("aw_hold", {aw_valid, aw_addr}, {1'b1, p_aw_addr});
      if (p_w)  chk("w_hold", {w_valid, w_last, w_data}, {1'b1, p_w_last, p_w_data});

      if (rst_beat >= 0 && r_ready && rb == rst_beat) begin
        idle_inputs();
        rst = 1;
        @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_valids", {ar_valid, r_ready, aw_valid, w_valid, b_ready, rsp_valid}, 0);
        chk("rst_rdata", rsp_rdata, 0);
        rst = 0;
        void'(rsp_q.pop_front());
        return;
      end

      if (rsp_valid) begin
        got = rsp_q.pop_front();
        chk("rsp_err", rsp_err, got.err);
        if (got.is_rd) begin
          chk("rsp_rdata", rsp_rdata, got.rdata);
          chk("r_beats", rb, LB);
        end else begin
          chk("w_beats", wb, LB);
          chk("b_count", nb, 1);
        end
        if (exp_lat > 0) chk("rsp_latency", n, exp_lat);
        idle_inputs();
        done = 1;
      end else begin
        ar_ready = ar_valid && go(busy);
        if (ar_valid && ar_ready) begin
          chk("ar_addr", ar_addr, base);
          chk("ar_attr", {ar_id, ar_len, ar_size, ar_burst, ar_cache, ar_prot},
              {7'd0, 8'd3, 3'd4, 2'd1, 4'd2, 3'd0});
        end

        r_valid = 0; r_last = 0;
        if (r_ready && rb < LB && go(busy)) begin
          r_valid = 1;
          r_data  = rd_mem(longint'(base) + rb * SW);
          r_resp  = (rb == err_beat) ? 2'b10 : 2'b00;
          r_last  = (rb == last_beat);
          r_id    = '0;
          rb++;
        end

        aw_ready = aw_valid && (n > aw_delay) && go(busy);
        if (aw_valid && aw_ready) begin
          chk("aw_addr", aw_addr, base);
          chk("aw_attr", {aw_id, aw_len, aw_size, aw_burst, aw_cache, aw_prot},
              {7'd0, 8'd3, 3'd4, 2'd1, 4'd2, 3'd0});
        end

        w_ready = w_valid && go(busy);
        if (w_valid && w_ready) begin
          exp_beat = wbeat_q.pop_front();
          chk("w_data", w_data, exp_beat);
          chk("w_last", w_last, (wb == LB - 1));
          chk("w_strb", w_strb, {SW{1'b1}});
          wb++;
        end

        b_valid = 0;
        if (b_ready && nb == 0 && go(busy)) begin
          b_valid = 1;
          b_resp  = b_bad ? 2'b10 : 2'b00;
          b_id    = '0;
          nb++;
        end

        p_ar = ar_valid && !ar_ready; p_ar_addr = ar_addr;
        p_aw = aw_valid && !aw_ready; p_aw_addr = aw_addr;
        p_w  = w_valid && !w_ready;   p_w_data  = w_data; p_w_last = w_last;
      end
    end
    chk("txn_timeout", done, 1);
  endtask

  initial begin
    logic [LW-1:0] line;
    bit            we;
    logic [AW-1:0] a;

    repeat (2) @(negedge clk);
    chk("reset_req_ready", req_ready, 1);
    chk("reset_valids", {ar_valid, aw_valid, w_valid, r_ready, b_ready, rsp_valid, w_last}, 0);
    chk("reset_rsp_err", rsp_err, 0);
    chk("reset_rsp_rdata", rsp_rdata, 0);
    chk("reset_addrs", {ar_addr, aw_addr, w_data}, 0);
    rst = 0;

    // Stray responses while idle must be ignored.
    r_valid = 1; b_valid = 1;
    repeat (2) @(negedge clk);
    chk("stray_idle", {req_ready, rsp_valid, r_ready, b_ready}, 4'b1000);
    idle_inputs();

    for (int i = 0; i < LB; i++) mem[64'h1200 + i * SW] = DW'(32'hA + i);
    run_txn(0, 48'h1234, '0, 0, 0, -1, LB - 1, 0, 6, -1);

    line = '0;
    for (int i = 0; i < LB; i++) line[i*DW +: DW] = DW'(8'h11 * (i + 1));
    run_txn(1, 48'h2040, line, 0, 5, -1, LB - 1, 0, 0, -1);
    run_txn(0, 48'h2044, '0, 0, 0, -1, LB - 1, 0, 6, -1);

    run_txn(0, 48'h1200, '0, 0, 0, 2, LB - 1, 0, 6, -1);
    run_txn(0, 48'h1200, '0, 0, 0, -1, 1, 0, 6, -1);
    run_txn(1, 48'h3000, rand_line(), 0, 0, -1, LB - 1, 1, 6, -1);

    run_txn(0, 48'h1200, '0, 0, 0, -1, LB - 1, 0, 0, 1);
    run_txn(0, 48'h1234, '0, 0, 0, -1, LB - 1, 0, 6, -1);

    for (int t = 0; t < 200; t++) begin
      we = 1'($urandom_range(1));
      a  = AW'({$urandom_range(15), 6'($urandom_range(63))});
      run_txn(we, a, rand_line(), 30, $urandom_range(3), -1, LB - 1, 0, 0, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
